issue_scoreboard: RTL

- Parametrised hazard and issue stage for the next-generation core; generalises the single-cycle load-use stall to multi-cycle result latencies.
- Sits between decode and execute. Tracks pending writes per register with countdown timers.
- Holds each instruction until its sources are ready or forwardable, and registers it into execute with a valid/ready handshake and forward selects.
- Register 0 is hard-wired zero and never tracked.

---
 rtl/issue_scoreboard.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/issue_scoreboard.sv
// Hazard/issue stage: per-register result countdowns gate decode into a
// single-entry execute register with bypass selects and a saturating stall counter.
module issue_scoreboard #(
   parameter int unsigned NREG   = 64,
   parameter int unsigned REG_W  = 6,
   parameter int unsigned LAT_W  = 3,
   parameter int unsigned FWD_EN = 1,
   parameter int unsigned PERF_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [REG_W-1:0]  in_rs1,
   input  logic [REG_W-1:0]  in_rs2,
   input  logic              in_rs1_use,
   input  logic              in_rs2_use,
   input  logic [REG_W-1:0]  in_rd,
   input  logic              in_rd_we,
   input  logic [LAT_W-1:0]  in_lat,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [REG_W-1:0]  out_rs1,
   output logic [REG_W-1:0]  out_rs2,
   output logic [REG_W-1:0]  out_rd,
   output logic              out_rd_we,
   output logic              out_fwd1,
   output logic              out_fwd2,
   input  logic              flush,
   output logic [PERF_W-1:0] stall_cycles
);

   localparam logic FWD = (FWD_EN != 0);
   localparam logic [LAT_W-1:0] ONE = LAT_W'(1);

   logic [LAT_W-1:0]  cnt_q [NREG];
   logic [LAT_W-1:0]  cnt_d [NREG];
   logic              out_valid_q, out_valid_d;
   logic [REG_W-1:0]  out_rs1_q, out_rs1_d;
   logic [REG_W-1:0]  out_rs2_q, out_rs2_d;
   logic [REG_W-1:0]  out_rd_q, out_rd_d;
   logic              out_rd_we_q, out_rd_we_d;
   logic              out_fwd1_q, out_fwd1_d;
   logic              out_fwd2_q, out_fwd2_d;
   logic [PERF_W-1:0] stall_q, stall_d;

   logic [LAT_W-1:0]  lat_e;
   logic [LAT_W-1:0]  cnt_s1, cnt_s2, cnt_rd;
   logic              s1_live, s2_live, rd_live;
   logic              blk1, blk2, blk_waw;
   logic              issue;

   always_comb begin
      lat_e   = (in_lat == '0) ? ONE : in_lat;
      cnt_s1  = cnt_q[in_rs1];
      cnt_s2  = cnt_q[in_rs2];
      cnt_rd  = cnt_q[in_rd];
      s1_live = in_rs1_use && (in_rs1 != '0);
      s2_live = in_rs2_use && (in_rs2 != '0);
      rd_live = in_rd_we && (in_rd != '0);
      blk1    = s1_live && ((cnt_s1 > ONE) || ((cnt_s1 == ONE) && !FWD));
      blk2    = s2_live && ((cnt_s2 > ONE) || ((cnt_s2 == ONE) && !FWD));
      blk_waw = rd_live && (cnt_rd > lat_e);
      in_ready = !flush && (!out_valid_q || out_ready) && !blk1 && !blk2 && !blk_waw;
      issue    = in_valid && in_ready;
   end

   // Decrement everything first, then let the issuing write override its own entry.
   always_comb begin
      for (int unsigned r = 0; r < NREG; r++) begin
         cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - ONE : '0;
      end
      if (issue && rd_live) begin
         cnt_d[in_rd] = lat_e;
      end
      cnt_d[0] = '0;
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_rs1_d   = out_rs1_q;
      out_rs2_d   = out_rs2_q;
      out_rd_d    = out_rd_q;
      out_rd_we_d = out_rd_we_q;
      out_fwd1_d  = out_fwd1_q;
      out_fwd2_d  = out_fwd2_q;
      stall_d     = stall_q;
      if (issue) begin
         out_valid_d = 1'b1;
         out_rs1_d   = in_rs1;
         out_rs2_d   = in_rs2;
         out_rd_d    = in_rd;
         out_rd_we_d = in_rd_we;
         out_fwd1_d  = FWD && s1_live && (cnt_s1 == ONE);
         out_fwd2_d  = FWD && s2_live && (cnt_s2 == ONE);
      end else if (out_ready || flush) begin
         out_valid_d = 1'b0;
      end
      if (in_valid && !in_ready && !flush && (stall_q != '1)) begin
         stall_d = stall_q + PERF_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned r = 0; r < NREG; r++) begin
            cnt_q[r] <= '0;
         end
         out_valid_q <= 1'b0;
         out_rs1_q   <= '0;
         out_rs2_q   <= '0;
         out_rd_q    <= '0;
         out_rd_we_q <= 1'b0;
         out_fwd1_q  <= 1'b0;
         out_fwd2_q  <= 1'b0;
         stall_q     <= '0;
      end else begin
         for (int unsigned r = 0; r < NREG; r++) begin
            cnt_q[r] <= cnt_d[r];
         end
         out_valid_q <= out_valid_d;
         out_rs1_q   <= out_rs1_d;
         out_rs2_q   <= out_rs2_d;
         out_rd_q    <= out_rd_d;
         out_rd_we_q <= out_rd_we_d;
         out_fwd1_q  <= out_fwd1_d;
         out_fwd2_q  <= out_fwd2_d;
         stall_q     <= stall_d;
      end
   end

   always_comb begin
      out_valid    = out_valid_q;
      out_rs1      = out_rs1_q;
      out_rs2      = out_rs2_q;
      out_rd       = out_rd_q;
      out_rd_we    = out_rd_we_q;
      out_fwd1     = out_fwd1_q;
      out_fwd2     = out_fwd2_q;
      stall_cycles = stall_q;
   end

endmodule
